// File: rtl/phase_freq_detector_meas.sv
// phase_freq_detector_meas
//   Phase/frequency detector for the PLL loop. Synchronises the reference (A)
//   and feedback (B) inputs, finds their rising edges and measures how many
//   clk_i cycles separate them. The signed result, slip and lock status go
//   to the digital loop filter.
//
// Ports
//   clk_i         system clock, all logic on the rising edge
//   reset_i       synchronous active-low reset
//   enable_i      measurement enable (synchronisers keep running when low)
//   signalA_i     reference input, asynchronous
//   signalB_i     feedback input, asynchronous
//   forwarding_o  A has risen and B is awaited
//   slowing_o     B has risen and A is awaited
//   phase_err_o   signed edge separation, positive = A leads, saturates at +/-MAX
//   err_valid_o   one-cycle strobe for a new phase_err_o
//   slip_o        one-cycle strobe: the leading input rose twice
//   locked_o      LOCK_CNT consecutive in-tolerance results seen

// Per-input synchroniser plus rising-edge detector.
module pfd_edge_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      // Shift form works for SYNC_STAGES == 1 as well.
      sync_q <= (sync_q << 1) | SYNC_STAGES'(sig_i);
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

module phase_freq_detector_meas #(
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    signalA_i,
  input  logic                    signalB_i,
  output logic                    forwarding_o,
  output logic                    slowing_o,
  output logic signed [ERR_W-1:0] phase_err_o,
  output logic                    err_valid_o,
  output logic                    slip_o,
  output logic                    locked_o
);

  localparam int NUM_LANES = 2;
  localparam int CNT_W     = ERR_W - 1;
  localparam int GOOD_W    = $clog2(LOCK_CNT + 1);

  // All-ones in CNT_W bits is exactly MAX = 2^(ERR_W-1)-1, so the count
  // can never reach -2^(ERR_W-1) when negated.
  localparam logic [CNT_W-1:0]  MAX_CNT   = '1;
  localparam logic [CNT_W-1:0]  TOL       = CNT_W'(LOCK_TOL);
  localparam logic [GOOD_W-1:0] LOCK_FULL = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE = 2'd0, A_LEAD = 2'd1, B_LEAD = 2'd2} state_t;

  // Lane 0 = A (reference), lane 1 = B (feedback).
  logic [NUM_LANES-1:0] sig_in;
  logic [NUM_LANES-1:0] rise;
  logic                 rise_a;
  logic                 rise_b;

  assign sig_in = {signalB_i, signalA_i};
  assign rise_a = rise[0];
  assign rise_b = rise[1];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pfd_edge_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .sig_i  (sig_in[l]),
      .rise_o (rise[l])
    );
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [GOOD_W-1:0]       good_q, good_inc;
  logic                    ev_vld;
  logic                    ev_slip;
  logic                    ev_in_tol;
  logic signed [ERR_W-1:0] ev_err;

  assign cnt_inc  = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + CNT_W'(1);
  assign good_inc = (good_q == LOCK_FULL) ? LOCK_FULL : good_q + GOOD_W'(1);

  // Next-state and measurement decode. ev_* describe the result that is
  // registered onto the outputs at the coming edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ev_vld    = 1'b0;
    ev_slip   = 1'b0;
    ev_in_tol = 1'b0;
    ev_err    = '0;
    unique case (state_q)
      IDLE: begin
        if (rise_a && rise_b) begin
          ev_vld    = 1'b1;
          ev_in_tol = 1'b1;
        end else if (rise_a) begin
          state_d = A_LEAD;
          cnt_d   = CNT_W'(1);
        end else if (rise_b) begin
          state_d = B_LEAD;
          cnt_d   = CNT_W'(1);
        end
      end
      A_LEAD: begin
        if (rise_b) begin
          ev_vld    = 1'b1;
          ev_err    = {1'b0, cnt_q};
          ev_in_tol = (cnt_q <= TOL);
          // A rising together with the closing B starts the next measurement.
          if (rise_a) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (rise_a) begin
          ev_vld  = 1'b1;
          ev_slip = 1'b1;
          ev_err  = {1'b0, MAX_CNT};
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      B_LEAD: begin
        if (rise_a) begin
          ev_vld    = 1'b1;
          ev_err    = -$signed({1'b0, cnt_q});
          ev_in_tol = (cnt_q <= TOL);
          if (rise_b) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (rise_b) begin
          ev_vld  = 1'b1;
          ev_slip = 1'b1;
          ev_err  = -$signed({1'b0, MAX_CNT});
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      ev_vld  = 1'b0;
      ev_slip = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      good_q       <= '0;
      forwarding_o <= 1'b0;
      slowing_o    <= 1'b0;
      phase_err_o  <= '0;
      err_valid_o  <= 1'b0;
      slip_o       <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      forwarding_o <= (state_d == A_LEAD);
      slowing_o    <= (state_d == B_LEAD);
      err_valid_o  <= ev_vld;
      slip_o       <= ev_slip;
      if (ev_vld) phase_err_o <= ev_err;
      // Lock tracks the result being strobed out, so locked_o changes in
      // the same cycle as the err_valid_o that decides it.
      if (!enable_i) begin
        good_q   <= '0;
        locked_o <= 1'b0;
      end else if (ev_vld) begin
        if (ev_in_tol && !ev_slip) begin
          good_q   <= good_inc;
          locked_o <= (good_inc == LOCK_FULL);
        end else begin
          good_q   <= '0;
          locked_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_freq_detector_meas.sv
module tb_phase_freq_detector_meas;

  localparam int ERR_W = 8;
  localparam int SYNC  = 2;
  localparam int TOL   = 2;
  localparam int LCNT  = 16;
  localparam int MAXV  = 127;
  localparam int MAXC  = 10000;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic enable_i = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic forwarding_o, slowing_o, err_valid_o, slip_o, locked_o;
  logic signed [ERR_W-1:0] phase_err_o;

  phase_freq_detector_meas #(
    .ERR_W(ERR_W), .SYNC_STAGES(SYNC), .LOCK_TOL(TOL), .LOCK_CNT(LCNT)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .signalA_i   (a),
    .signalB_i   (b),
    .forwarding_o(forwarding_o),
    .slowing_o   (slowing_o),
    .phase_err_o (phase_err_o),
    .err_valid_o (err_valid_o),
    .slip_o      (slip_o),
    .locked_o    (locked_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int d; int exp_err; int exp_fwd; int exp_slw;} vec_t;
  typedef struct {int err; bit slp; bit lck;} res_t;

  int n_chk = 0;
  int n_fail = 0;

  // Monitor: every result strobe, plus cycle counts of the lead outputs.
  res_t dut_q[$];
  int   fwd_cyc = 0;
  int   slw_cyc = 0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      if (err_valid_o) dut_q.push_back(res_t'{int'(phase_err_o), bit'(slip_o), bit'(locked_o)});
      if (forwarding_o) fwd_cyc <= fwd_cyc + 1;
      if (slowing_o) slw_cyc <= slw_cyc + 1;
    end
  end

  // Pulse schedule: one-cycle-high input pulses, indexed by cycle.
  bit   sch_a[MAXC];
  bit   sch_b[MAXC];
  res_t exp_q[$];
  int   m_good;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_sched();
    for (int i = 0; i < MAXC; i++) begin
      sch_a[i] = 1'b0;
      sch_b[i] = 1'b0;
    end
  endtask

  task automatic place_pair(inout int cur, input int d);
    if (d < 0) begin
      sch_b[cur] = 1'b1;
      sch_a[cur - d] = 1'b1;
      cur += -d;
    end else begin
      sch_a[cur] = 1'b1;
      sch_b[cur + d] = 1'b1;
      cur += d;
    end
    cur += int'($urandom_range(2, 6));
  endtask

  task automatic run_sched(input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk_i);
      a = sch_a[c];
      b = sch_b[c];
    end
    @(negedge clk_i);
    a = 1'b0;
    b = 1'b0;
    repeat (8) @(negedge clk_i);
  endtask

  // Clear state and lock history through the enable.
  task automatic fresh();
    @(negedge clk_i);
    a = 1'b0;
    b = 1'b0;
    enable_i = 1'b0;
    @(negedge clk_i);
    enable_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic emit(input int err, input bit slp);
    int mag;
    mag = (err < 0) ? -err : err;
    if (!slp && mag <= TOL) m_good = (m_good < LCNT) ? m_good + 1 : LCNT;
    else m_good = 0;
    exp_q.push_back(res_t'{err, slp, (m_good == LCNT)});
  endtask

  // Reference: results from pulse timestamps. The earlier edge opens a
  // measurement, the other input closes it with the cycle difference; a
  // second edge of the leading input is a slip.
  task automatic model(input int len);
    int pend;  // 0 none, 1 waiting for B, 2 waiting for A
    int t0;
    int dt;
    pend = 0;
    t0 = 0;
    m_good = 0;
    exp_q.delete();
    for (int c = 0; c < len; c++) begin
      dt = (c - t0 > MAXV) ? MAXV : c - t0;
      if (pend == 0) begin
        if (sch_a[c] && sch_b[c]) emit(0, 1'b0);
        else if (sch_a[c]) begin pend = 1; t0 = c; end
        else if (sch_b[c]) begin pend = 2; t0 = c; end
      end else if (pend == 1) begin
        if (sch_b[c]) begin
          emit(dt, 1'b0);
          if (sch_a[c]) t0 = c; else pend = 0;
        end else if (sch_a[c]) begin
          emit(MAXV, 1'b1);
          t0 = c;
        end
      end else begin
        if (sch_a[c]) begin
          emit(-dt, 1'b0);
          if (sch_b[c]) t0 = c; else pend = 0;
        end else if (sch_b[c]) begin
          emit(-MAXV, 1'b1);
          t0 = c;
        end
      end
    end
  endtask

  task automatic cmp_model(input string tag, input int start);
    check($sformatf("%s count", tag), dut_q.size() - start, exp_q.size());
    for (int i = 0; i < exp_q.size() && start + i < dut_q.size(); i++) begin
      check($sformatf("%s[%0d] err", tag, i), dut_q[start+i].err, exp_q[i].err);
      check($sformatf("%s[%0d] slip", tag, i), int'(dut_q[start+i].slp), int'(exp_q[i].slp));
      check($sformatf("%s[%0d] lock", tag, i), int'(dut_q[start+i].lck), int'(exp_q[i].lck));
    end
  endtask

  function automatic res_t got(input int idx);
    if (idx < dut_q.size()) return dut_q[idx];
    return res_t'{-999, 1'b0, 1'b0};
  endfunction

  // Inputs held high; the later one rises |d| cycles after the earlier.
  task automatic do_pair(input int d, output int nval, output int err, output int slp,
                         output int fwd, output int slw);
    int ta, tb, len;
    ta = (d < 0) ? -d : 0;
    tb = (d < 0) ? 0 : d;
    len = ta + tb + SYNC + 8;
    nval = 0; err = 0; slp = 0; fwd = 0; slw = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk_i);
      if (forwarding_o) fwd++;
      if (slowing_o) slw++;
      if (err_valid_o) begin
        nval++;
        err = int'(phase_err_o);
        slp = int'(slip_o);
      end
      if (c == ta) a = 1'b1;
      if (c == tb) b = 1'b1;
    end
    a = 1'b0;
    b = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  vec_t tbl[9];

  initial begin
    int   nval, err, slp, fwd, slw, s, f0, w0, cur, len, k;
    res_t r;

    tbl = '{'{5, 5, 5, 0}, '{-3, -3, 0, 3}, '{0, 0, 0, 0}, '{1, 1, 1, 0},
            '{-1, -1, 0, 1}, '{126, 126, 126, 0}, '{127, 127, 127, 0},
            '{200, 127, 200, 0}, '{-150, -127, 0, 150}};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst fwd", int'(forwarding_o), 0);
    check("rst slw", int'(slowing_o), 0);
    check("rst err", int'(phase_err_o), 0);
    check("rst valid", int'(err_valid_o), 0);
    check("rst slip", int'(slip_o), 0);
    check("rst lock", int'(locked_o), 0);
    reset_i = 1'b1;
    enable_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // Directed separations
    foreach (tbl[i]) begin
      do_pair(tbl[i].d, nval, err, slp, fwd, slw);
      check($sformatf("vec%0d nvalid", i), nval, 1);
      check($sformatf("vec%0d err", i), err, tbl[i].exp_err);
      check($sformatf("vec%0d slip", i), slp, 0);
      check($sformatf("vec%0d fwd_cycles", i), fwd, tbl[i].exp_fwd);
      check($sformatf("vec%0d slw_cycles", i), slw, tbl[i].exp_slw);
    end

    // Slip: two A edges 20 apart, then B 300 after the second A
    fresh();
    clr_sched();
    sch_a[2] = 1'b1;
    sch_a[22] = 1'b1;
    sch_b[322] = 1'b1;
    s = dut_q.size(); f0 = fwd_cyc; w0 = slw_cyc;
    run_sched(330);
    check("slip count", dut_q.size() - s, 2);
    r = got(s);
    check("slip err", r.err, MAXV);
    check("slip flag", int'(r.slp), 1);
    r = got(s + 1);
    check("sat err", r.err, MAXV);
    check("sat slip", int'(r.slp), 0);
    check("slip fwd_cycles", fwd_cyc - f0, 320);
    check("slip slw_cycles", slw_cyc - w0, 0);

    // Lock: 16 good, one +5, 16 good, then a slip
    fresh();
    clr_sched();
    cur = 2;
    for (int i = 0; i < 16; i++) place_pair(cur, (i % 5) - 2);
    place_pair(cur, 5);
    for (int i = 0; i < 16; i++) place_pair(cur, (i % 5) - 2);
    sch_a[cur] = 1'b1;
    sch_a[cur+10] = 1'b1;
    sch_b[cur+20] = 1'b1;
    len = cur + 22;
    s = dut_q.size();
    run_sched(len);
    check("lock count", dut_q.size() - s, 35);
    check("lock idx14", int'(got(s + 14).lck), 0);
    check("lock idx15", int'(got(s + 15).lck), 1);
    check("unlock err", got(s + 16).err, 5);
    check("unlock lock", int'(got(s + 16).lck), 0);
    check("relock idx32", int'(got(s + 32).lck), 1);
    check("slip idx33 flag", int'(got(s + 33).slp), 1);
    check("slip idx33 lock", int'(got(s + 33).lck), 0);
    check("close idx34 err", got(s + 34).err, 10);
    model(len);
    cmp_model("lockseq", s);

    // Reset in the middle of A_LEAD
    @(negedge clk_i); a = 1'b1;
    @(negedge clk_i); a = 1'b0;
    repeat (5) @(negedge clk_i);
    check("pre-reset fwd", int'(forwarding_o), 1);
    reset_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    check("mid rst fwd", int'(forwarding_o), 0);
    check("mid rst slw", int'(slowing_o), 0);
    check("mid rst err", int'(phase_err_o), 0);
    check("mid rst valid", int'(err_valid_o), 0);
    check("mid rst slip", int'(slip_o), 0);
    check("mid rst lock", int'(locked_o), 0);
    repeat (3) @(negedge clk_i);
    clr_sched();
    sch_b[5] = 1'b1;
    sch_a[45] = 1'b1;
    s = dut_q.size(); f0 = fwd_cyc; w0 = slw_cyc;
    run_sched(50);
    check("post rst count", dut_q.size() - s, 1);
    check("post rst err", got(s).err, -40);
    check("post rst slw_cycles", slw_cyc - w0, 40);
    check("post rst fwd_cycles", fwd_cyc - f0, 0);

    // Enable low during A_LEAD: measurement dropped, result held
    @(negedge clk_i); a = 1'b1;
    @(negedge clk_i); a = 1'b0;
    repeat (5) @(negedge clk_i);
    s = dut_q.size();
    enable_i = 1'b0;
    @(negedge clk_i);
    check("dis fwd", int'(forwarding_o), 0);
    b = 1'b1;
    @(negedge clk_i); b = 1'b0;
    repeat (8) @(negedge clk_i);
    check("dis strobes", dut_q.size() - s, 0);
    check("dis err hold", int'(phase_err_o), -40);
    check("dis slw", int'(slowing_o), 0);
    enable_i = 1'b1;

    // Randomized transactions against the timestamp model
    fresh();
    clr_sched();
    cur = 4;
    while (cur < 9000) begin
      k = int'($urandom_range(0, 9));
      if (k <= 4) place_pair(cur, int'($urandom_range(0, 4)) - 2);
      else if (k == 5) repeat (18) place_pair(cur, int'($urandom_range(0, 4)) - 2);
      else if (k == 6) place_pair(cur, int'($urandom_range(0, 300)) - 150);
      else if (k == 7) begin sch_a[cur] = 1'b1; cur += int'($urandom_range(2, 6)); end
      else if (k == 8) begin sch_b[cur] = 1'b1; cur += int'($urandom_range(2, 6)); end
      else cur += int'($urandom_range(140, 260));
    end
    len = cur + 2;
    s = dut_q.size();
    run_sched(len);
    model(len);
    cmp_model("rand", s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
